// File: rtl/seg_display_driver.sv
// seg_display_driver: multiplexed 4-digit common-anode 7-segment driver.
// A free-running divider rotates through the digits. Digit data is taken into
// a shadow register on `load` so a scan never mixes old and new data.
// Optional feature macro: SEG_BLINK_EN adds a per-digit blink mask and phase.
module seg_display_driver #(
  parameter int REFRESH_DIV = 100000
`ifdef SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
`ifdef SEG_BLINK_EN
  input  logic [3:0]  blink,
`endif
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [15:0]      sh_digits;
  logic [3:0]       sh_dp;
  logic [3:0]       sh_blank;

  logic             terminal;
  logic [1:0]       idx_nxt;
  logic [3:0]       digit_nxt;
  logic             hide_nxt;

`ifdef SEG_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

  logic [FR_W-1:0]  frame_cnt;
  logic             blink_phase;
  logic [3:0]       sh_blink;
  logic             frame_wrap;
  logic             phase_nxt;
`endif

  // Hex digit to active-low gfedcba pattern
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Post-edge scan position and what the newly selected digit should show
  always_comb begin
    terminal  = (div_cnt == DIV_LAST);
    idx_nxt   = terminal ? idx + 2'd1 : idx;
    digit_nxt = sh_digits[{idx_nxt, 2'b00} +: 4];
`ifdef SEG_BLINK_EN
    frame_wrap = terminal && (idx == 2'd3);
    phase_nxt  = (frame_wrap && (frame_cnt == FR_LAST)) ? ~blink_phase : blink_phase;
    hide_nxt   = sh_blank[idx_nxt] | (phase_nxt & sh_blink[idx_nxt]);
`else
    hide_nxt   = sh_blank[idx_nxt];
`endif
  end

  // Refresh divider and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else begin
      div_cnt <= terminal ? '0 : div_cnt + 1'b1;
      idx     <= idx_nxt;
    end
  end

  // Shadow register: captured on load, independent of scan position
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
    end else if (load) begin
      sh_digits <= digits;
      sh_dp     <= dp;
      sh_blank  <= blank;
    end
  end

`ifdef SEG_BLINK_EN
  // Frame counter and blink phase; blink mask rides with the shadow register
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_blink    <= '0;
    end else begin
      if (frame_wrap) begin
        frame_cnt <= (frame_cnt == FR_LAST) ? '0 : frame_cnt + 1'b1;
      end
      blink_phase <= phase_nxt;
      if (load) begin
        sh_blink <= blink;
      end
    end
  end
`endif

  // Registered display outputs; a hidden digit turns everything off
  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= 4'b1110;
      seg  <= 7'b1000000;
      dp_n <= 1'b1;
    end else if (hide_nxt) begin
      an   <= 4'b1111;
      seg  <= 7'b1111111;
      dp_n <= 1'b1;
    end else begin
      an   <= ~(4'b0001 << idx_nxt);
      seg  <= hex7(digit_nxt);
      dp_n <= ~sh_dp[idx_nxt];
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with REFRESH_DIV=4 (one frame = 16 cycles).
module tb_seg_display_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp = 4'b0000;
  logic [3:0]  blank = 4'b0000;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink = 4'b0000;
`endif
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;

  int n_assert = 0;
  int n_fail = 0;
  int pos = 0;    // expected idx*4 + div_cnt after the latest edge
  int frame = 0;  // frames completed since the last reset

  logic [3:0] an_tab [4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] scan_seg [4] = '{7'b1000000, 7'b1111000, 7'b0001000, 7'b0110000};

  seg_display_driver #(
    .REFRESH_DIV(4)
`ifdef SEG_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .digits(digits),
    .dp(dp),
    .blank(blank),
`ifdef SEG_BLINK_EN
    .blink(blink),
`endif
    .seg(seg),
    .dp_n(dp_n),
    .an(an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      pos = 0;
      frame = 0;
    end else begin
      pos = (pos + 1) % 16;
      if (pos == 0) frame++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] ea, input logic [6:0] es,
                          input logic ed);
    chk($sformatf("%s_an@%0d", tag, pos), {3'b000, an}, {3'b000, ea});
    chk($sformatf("%s_seg@%0d", tag, pos), seg, es);
    chk($sformatf("%s_dpn@%0d", tag, pos), {6'b000000, dp_n}, {6'b000000, ed});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ix;
    // Reset held three cycles
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_slot("reset", 4'b1110, 7'b1000000, 1'b1);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_slot("rst_hold", 4'b1110, 7'b1000000, 1'b1);
    end
    tick();
    chk_slot("rst_adv", 4'b1101, 7'b1000000, 1'b1);

    // Scan and decode of 16'h3A70
    digits = 16'h3A70;
    load = 1'b1;
    tick();
    load = 1'b0;
    digits = 16'h0000;
    while (pos != 15) tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      ix = pos / 4;
      chk_slot("scan", an_tab[ix], scan_seg[ix], 1'b1);
    end

    // Decimal point on digit 1, digit 3 blanked
    digits = 16'h3A70;
    dp = 4'b0010;
    blank = 4'b1000;
    load = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) begin
        load = 1'b0;
        dp = 4'b0000;
        blank = 4'b0000;
        digits = 16'h0000;
      end
      ix = pos / 4;
      if (ix == 3) chk_slot("blank", 4'b1111, 7'b1111111, 1'b1);
      else chk_slot("dp", an_tab[ix], scan_seg[ix], (ix == 1) ? 1'b0 : 1'b1);
    end

    // Load while digit 2 is lit: current slot keeps old data until next edge
    while (pos != 9) tick();
    digits = 16'h0500;
    load = 1'b1;
    tick();
    load = 1'b0;
    digits = 16'hFFFF;
    chk_slot("no_tear", 4'b1011, 7'b0001000, 1'b1);
    for (int k = 0; k < 16; k++) begin
      tick();
      ix = pos / 4;
      chk_slot("latency", an_tab[ix], (ix == 2) ? 7'b0010010 : 7'b1000000, 1'b1);
    end

    // Mid-scan reset at idx=3, div_cnt=2 with load asserted (must be ignored)
    while (pos != 14) tick();
    rst = 1'b1;
    load = 1'b1;
    digits = 16'h8888;
    dp = 4'b1111;
    tick();
    chk_slot("midrst", 4'b1110, 7'b1000000, 1'b1);
    rst = 1'b0;
    load = 1'b0;
    digits = 16'h0000;
    dp = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      tick();
      ix = pos / 4;
      chk_slot("cleared", an_tab[ix], 7'b1000000, 1'b1);
    end

`ifdef SEG_BLINK_EN
    // Blink digit 0 with two frames per half-period
    rst = 1'b1;
    tick();
    rst = 1'b0;
    digits = 16'h0008;
    blink = 4'b0001;
    load = 1'b1;
    tick();
    load = 1'b0;
    digits = 16'h0000;
    blink = 4'b0000;
    for (int k = 0; k < 100 && frame < 5; k++) begin
      tick();
      if (frame < 5) begin
        ix = pos / 4;
        if (ix == 0 && ((frame / 2) % 2) == 1)
          chk_slot("blink_off", 4'b1111, 7'b1111111, 1'b1);
        else
          chk_slot("blink_on", an_tab[ix], (ix == 0) ? 7'b0000000 : 7'b1000000, 1'b1);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
